// File: rtl/alu_cmd_pkg.sv
// Shared types and constants for the ALU command entry front end.
package alu_cmd_pkg;

   localparam int unsigned DATA_W_DEF = 4;
   localparam int unsigned OP_W_DEF   = 3;

   // Opcodes understood by the downstream ALU/accumulator
   localparam logic [OP_W_DEF-1:0] OP_LOAD = 3'b000;
   localparam logic [OP_W_DEF-1:0] OP_ADD  = 3'b001;
   localparam logic [OP_W_DEF-1:0] OP_SUB  = 3'b010;
   localparam logic [OP_W_DEF-1:0] OP_AND  = 3'b011;
   localparam logic [OP_W_DEF-1:0] OP_OR   = 3'b100;
   localparam logic [OP_W_DEF-1:0] OP_XOR  = 3'b101;
   localparam logic [OP_W_DEF-1:0] OP_SHL  = 3'b110;
   localparam logic [OP_W_DEF-1:0] OP_CLR  = 3'b111;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GET_A = 2'b01,
      SEND  = 2'b10
   } state_t;

endpackage

// File: rtl/key_debounce.sv
// Key synchronizer, debouncer and falling-edge press detector.
// ALU_CMD_ENTRY_BYPASS_DEBOUNCE_EN removes the debounce counter (db_level follows s2).
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_press_c
);

   logic r_s1;
   logic r_s2;
   logic r_db_level_d;
   logic w_db_level;

   // Two-flop synchronizer; idle level is released (1)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1 <= 1'b1;
         r_s2 <= 1'b1;
      end else begin
         r_s1 <= i_key_n;
         r_s2 <= r_s1;
      end
   end

`ifdef ALU_CMD_ENTRY_BYPASS_DEBOUNCE_EN
   assign w_db_level = r_s2;
`else
   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             r_db_level;
   logic [CNT_W-1:0] r_cnt;

   // Level changes only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_db_level <= 1'b1;
         r_cnt      <= '0;
      end else if (r_s2 == r_db_level) begin
         r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         r_db_level <= r_s2;
         r_cnt      <= '0;
      end else begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign w_db_level = r_db_level;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_db_level_d <= 1'b1;
      end else begin
         r_db_level_d <= w_db_level;
      end
   end

   assign o_press_c = r_db_level_d & ~w_db_level;

endmodule

// File: rtl/alu_cmd_entry.sv
// Switch/push-button command entry: opcode press, operand press, valid/ready send.
// ALU_CMD_ENTRY_BYPASS_DEBOUNCE_EN (in key_debounce) selects the fast-sim no-debounce key path.
module alu_cmd_entry
   import alu_cmd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned DATA_W          = DATA_W_DEF,
   parameter int unsigned OP_W            = OP_W_DEF
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              key_n,
   input  logic [DATA_W-1:0] sw_data,
   input  logic [OP_W-1:0]   sw_op,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   output logic [OP_W-1:0]   cmd_op,
   output logic [DATA_W-1:0] cmd_data,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   logic              w_press_c;
   state_t            r_state;
   state_t            w_next_state;
   logic              w_cap_op;
   logic              w_cap_data;
   logic              r_cmd_valid;
   logic              r_busy;
   logic [OP_W-1:0]   r_cmd_op;
   logic [DATA_W-1:0] r_cmd_data;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .i_clk     (clock),
      .i_rst     (reset),
      .i_key_n   (key_n),
      .o_press_c (w_press_c)
   );

   // State register; valid/busy are registered decodes of the next state
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= IDLE;
         r_cmd_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_cmd_valid <= (w_next_state == SEND);
         r_busy      <= (w_next_state != IDLE);
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_cap_op     = 1'b0;
      w_cap_data   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_press_c) begin
               w_cap_op     = 1'b1;
               w_next_state = GET_A;
            end
         end
         GET_A: begin
            if (w_press_c) begin
               w_cap_data   = 1'b1;
               w_next_state = SEND;
            end
         end
         SEND: begin
            // Presses here are dropped; only the handshake leaves SEND
            if (r_cmd_valid && cmd_ready) begin
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   // Capture registers hold through SEND and retain their values in IDLE
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cmd_op   <= '0;
         r_cmd_data <= '0;
      end else begin
         if (w_cap_op) begin
            r_cmd_op <= sw_op;
         end
         if (w_cap_data) begin
            r_cmd_data <= sw_data;
         end
      end
   end

   assign cmd_valid = r_cmd_valid;
   assign cmd_op    = r_cmd_op;
   assign cmd_data  = r_cmd_data;
   assign busy      = r_busy;
   assign state_dbg = 2'(r_state);

endmodule

// File: tb/tb_alu_cmd_entry.sv
// Directed self-checking bench for alu_cmd_entry with DEBOUNCE_CYCLES=4.
module tb_alu_cmd_entry;

   localparam int unsigned DC = 4;

`ifdef ALU_CMD_ENTRY_BYPASS_DEBOUNCE_EN
   localparam int EXP_LAT = 3;
`else
   localparam int EXP_LAT = 7;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       key_n = 1'b1;
   logic [3:0] sw_data = 4'h0;
   logic [2:0] sw_op = 3'b000;
   logic       cmd_valid;
   logic       cmd_ready = 1'b0;
   logic [2:0] cmd_op;
   logic [3:0] cmd_data;
   logic       busy;
   logic [1:0] state_dbg;

   int errors = 0;
   int checks = 0;
   int xfers = 0;
   int valid_cycles = 0;
   logic [2:0] x_op = '0;
   logic [3:0] x_data = '0;

   alu_cmd_entry #(.DEBOUNCE_CYCLES(DC), .DATA_W(4), .OP_W(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .key_n     (key_n),
      .sw_data   (sw_data),
      .sw_op     (sw_op),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   always #5 clock = ~clock;

   // Transfer scoreboard: a transfer is valid&&ready on an edge without reset
   always @(posedge clock) begin
      if (!reset && cmd_valid === 1'b1) valid_cycles <= valid_cycles + 1;
      if (!reset && cmd_valid === 1'b1 && cmd_ready) begin
         xfers  <= xfers + 1;
         x_op   <= cmd_op;
         x_data <= cmd_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input int low_cycles);
      key_n = 1'b0;
      repeat (low_cycles) tick();
      key_n = 1'b1;
      repeat (12) tick();
   endtask

   task automatic wait_state(input string tag, input logic [1:0] s);
      int n = 0;
      while (state_dbg !== s && n < 60) begin
         tick();
         n++;
      end
      chk(tag, 32'(state_dbg), 32'(s));
   endtask

   int base_x;
   int base_v;
   int lat;
   logic bad_state;

   initial begin
      // Reset held with key toggling
      for (int i = 0; i < 3; i++) begin
         key_n = ~key_n;
         tick();
         chk("rst_valid", 32'(cmd_valid), 32'd0);
         chk("rst_op",    32'(cmd_op),    32'd0);
         chk("rst_data",  32'(cmd_data),  32'd0);
         chk("rst_busy",  32'(busy),      32'd0);
         chk("rst_state", 32'(state_dbg), 32'd0);
      end
      key_n = 1'b1;
      repeat (12) tick();
      reset = 1'b0;
      repeat (2) tick();

      // Clean entry with ready already high
      cmd_ready = 1'b1;
      base_x = xfers;
      base_v = valid_cycles;
      sw_op = 3'b011;
      press(10);
      chk("clean_get_a", 32'(state_dbg), 32'd1);
      chk("clean_busy",  32'(busy),      32'd1);
      sw_data = 4'hA;
      press(10);
      chk("clean_xfers",  32'(xfers - base_x),        32'd1);
      chk("clean_vcyc",   32'(valid_cycles - base_v), 32'd1);
      chk("clean_x_op",   32'(x_op),      32'h3);
      chk("clean_x_data", 32'(x_data),    32'hA);
      chk("clean_idle",   32'(state_dbg), 32'd0);
      chk("clean_hold_op", 32'(cmd_op),   32'h3);

      // Bounce rejection
      bad_state = 1'b0;
      key_n = 1'b0; repeat (3) tick();
      key_n = 1'b1; tick();
      key_n = 1'b0; repeat (3) tick();
      key_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (state_dbg !== 2'b00) bad_state = 1'b1;
      end
`ifndef ALU_CMD_ENTRY_BYPASS_DEBOUNCE_EN
      chk("bounce_no_press", 32'(bad_state), 32'd0);
      chk("bounce_idle",     32'(state_dbg), 32'd0);
`endif
      if (state_dbg !== 2'b00) begin
         reset = 1'b1; tick(); reset = 1'b0; tick();
      end

      // Backpressure with extra presses in SEND
      cmd_ready = 1'b0;
      base_x = xfers;
      sw_op = 3'b101;
      press(6);
      sw_data = 4'h6;
      press(6);
      wait_state("bp_send", 2'b10);
      chk("bp_valid", 32'(cmd_valid), 32'd1);
      sw_data = 4'h9;
      sw_op = 3'b010;
      press(6);
      press(6);
      chk("bp_valid_held", 32'(cmd_valid), 32'd1);
      chk("bp_data_held",  32'(cmd_data),  32'h6);
      chk("bp_op_held",    32'(cmd_op),    32'h5);
      chk("bp_no_xfer",    32'(xfers - base_x), 32'd0);
      cmd_ready = 1'b1;
      tick();
      chk("bp_xfer",       32'(xfers - base_x), 32'd1);
      chk("bp_x_data",     32'(x_data),    32'h6);
      chk("bp_valid_drop", 32'(cmd_valid), 32'd0);
      chk("bp_idle",       32'(state_dbg), 32'd0);
      repeat (10) tick();
      chk("bp_still_idle", 32'(state_dbg), 32'd0);
      chk("bp_one_xfer",   32'(xfers - base_x), 32'd1);

      // Reset while in SEND
      cmd_ready = 1'b0;
      press(6);
      press(6);
      wait_state("rs_send", 2'b10);
      base_x = xfers;
      reset = 1'b1;
      cmd_ready = 1'b1;
      tick();
      chk("rs_valid", 32'(cmd_valid), 32'd0);
      chk("rs_state", 32'(state_dbg), 32'd0);
      chk("rs_busy",  32'(busy),      32'd0);
      chk("rs_no_xfer", 32'(xfers - base_x), 32'd0);
      reset = 1'b0;
      repeat (3) tick();

      // Latency from key fall to GET_A capture edge
      key_n = 1'b0;
      lat = 0;
      while (state_dbg !== 2'b01 && lat < 50) begin
         tick();
         lat++;
      end
      chk("latency", 32'(lat), 32'(EXP_LAT));
      key_n = 1'b1;
      repeat (12) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
